// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system ID slave (ID, build timestamp) and flags match/mismatch.
// Optional periodic re-check is built when SYSID_CHECKER_PERIODIC_EN is defined.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1370770100,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned RECHECK_CYCLES     = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic        ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    CMP   = 2'd3
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return (a == b);
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [15:0] wait_cnt_r;
  logic        start_s;
  logic        begin_s;
  logic        reading_s;
  logic        accept_s;
  logic        expire_s;
  logic        cmp_s;

`ifdef SYSID_CHECKER_PERIODIC_EN
  localparam logic [31:0] RECHECK_LAST = 32'(RECHECK_CYCLES - 1);

  logic [31:0] idle_cnt_r;
  logic        recheck_due_s;

  assign recheck_due_s = (state_r == IDLE) && (idle_cnt_r == RECHECK_LAST);
  assign start_s       = start | recheck_due_s;

  // Idle-time counter that launches an automatic check once the period elapses.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt_r <= 32'd0;
    end else if (begin_s || (state_r != IDLE)) begin
      idle_cnt_r <= 32'd0;
    end else begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end
  end
`else
  logic unused_recheck_s;

  assign unused_recheck_s = ^RECHECK_CYCLES;
  assign start_s          = start;
`endif

  assign reading_s = (state_r == RD_ID) || (state_r == RD_TS);
  assign accept_s  = reading_s && !m_waitrequest;
  // The stall that would bring the counter up to TIMEOUT_CYCLES aborts the check.
  assign expire_s  = reading_s && m_waitrequest && (wait_cnt_r == WAIT_LAST);
  assign cmp_s     = (state_r == CMP);

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    begin_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = RD_ID;
          begin_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RD_ID: begin
        if (!m_waitrequest) begin
          state_s = RD_TS;
        end else if (expire_s) begin
          state_s = IDLE;
        end else begin
          state_s = RD_ID;
        end
      end
      RD_TS: begin
        if (!m_waitrequest) begin
          state_s = CMP;
        end else if (expire_s) begin
          state_s = IDLE;
        end else begin
          state_s = RD_TS;
        end
      end
      CMP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and bus/handshake outputs, all decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      m_read    <= 1'b0;
      m_address <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      m_read    <= (state_s == RD_ID) || (state_s == RD_TS);
      m_address <= (state_s == RD_TS);
      busy      <= (state_s != IDLE);
      done      <= cmp_s || expire_s;
    end
  end

  // Consecutive-stall counter, restarted for each of the two reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= 16'd0;
    end else if (begin_s || ((state_r == RD_ID) && accept_s)) begin
      wait_cnt_r <= 16'd0;
    end else if (reading_s && m_waitrequest) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Captured words survive a timeout; only a completed read replaces them.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      if ((state_r == RD_ID) && accept_s) begin
        id_value <= m_readdata;
      end
      if ((state_r == RD_TS) && accept_s) begin
        ts_value <= m_readdata;
      end
    end
  end

  // Status flags: cleared when a check begins, then set by compare or timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      ok      <= 1'b0;
      timeout <= 1'b0;
    end else if (begin_s) begin
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      ok      <= 1'b0;
      timeout <= 1'b0;
    end else if (cmp_s) begin
      id_ok   <= word_match(id_value, EXPECTED_ID);
      ts_ok   <= word_match(ts_value, EXPECTED_TIMESTAMP);
      ok      <= word_match(id_value, EXPECTED_ID) && word_match(ts_value, EXPECTED_TIMESTAMP);
      timeout <= 1'b0;
    end else if (expire_s) begin
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      ok      <= 1'b0;
      timeout <= 1'b1;
    end else begin
      id_ok   <= id_ok;
      ts_ok   <= ts_ok;
      ok      <= ok;
      timeout <= timeout;
    end
  end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM master that reads the two words of the system ID slave (word 0: system ID, word 1: build timestamp), compares them against expected values fixed at build time, and reports match or mismatch status. Sits directly downstream of the system ID slave on the control fabric. A boot supervisor or status LED consumes its outputs, so a mismatched bitstream/software pairing is flagged without a CPU.

## Interface
- EXPECTED_ID, 32'd0: value required at word 0.
- EXPECTED_TIMESTAMP, 32'd1370770100: value required at word 1.
- TIMEOUT_CYCLES, 255: maximum consecutive waitrequest cycles per read; range 1..65535.
- RECHECK_CYCLES, 50_000_000: idle cycles between automatic checks; used only with the Configuration macro.

- clock  in  1  sole clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a check; sampled only in IDLE.
- m_address  out  1  word select: 0 = ID, 1 = timestamp.
- m_read  out  1  Avalon read strobe.
- m_waitrequest  in  1  slave stall; tie 0 for direct connection to the ID slave.
- m_readdata  in  32  read data; valid in the cycle m_read=1 and m_waitrequest=0 (read latency 0).
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse when results are updated.
- id_ok  out  1  captured ID == EXPECTED_ID.
- ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP.
- timeout  out  1  a read exceeded TIMEOUT_CYCLES.
- ok  out  1  id_ok & ts_ok & ~timeout (registered).
- id_value  out  32  last captured ID.
- ts_value  out  32  last captured timestamp.

## Operation
- States: IDLE, RD_ID, RD_TS, CMP.
- IDLE: m_read=0, busy=0. If start=1 → RD_ID, clear id_ok/ts_ok/timeout/ok, and zero the wait counter.
- RD_ID: m_read=1, m_address=0. On m_waitrequest=0, capture m_readdata into id_value → RD_TS, zero the wait counter.
- RD_TS: m_read=1, m_address=1. On m_waitrequest=0, capture into ts_value → CMP.
- CMP: m_read=0. Register the full 32-bit equality compares into id_ok, ts_ok, and ok. Pulse done → IDLE.
- Wait counter: increments each RD_* cycle with m_waitrequest=1. On reaching TIMEOUT_CYCLES, drop m_read next cycle, set timeout=1, id_ok=ts_ok=ok=0, pulse done → IDLE. id_value/ts_value keep their last captured values.
- start while busy is ignored; it is not queued.
- m_address and m_read are stable while m_waitrequest=1.
- Status outputs hold until the next check begins.

## Timing
- Reset values: state IDLE, m_read=0, m_address=0, busy=0, done=0, id_ok=ts_ok=ok=0, timeout=0, id_value=ts_value=0, counters 0.
- Zero wait states, start sampled at edge E:
  - cycle after E: RD_ID, busy=1.
  - after E+1: RD_TS.
  - after E+2: CMP.
  - after E+3: done=1, busy=0, flags valid.
- Each waitrequest cycle adds one cycle of latency.
- reset mid-check: next edge forces IDLE. m_read deasserts that same edge and no done pulse is produced.
- start and reset in the same cycle: reset wins.

## Configuration
- SYSID_CHECKER_PERIODIC_EN defined:
  - A 32-bit idle counter runs in IDLE.
  - After RECHECK_CYCLES idle cycles, a check starts as if start=1.
  - The counter zeroes whenever a check begins. The first automatic check fires RECHECK_CYCLES after reset.
  - start still forces an immediate check.
- Not defined: the idle counter is absent, and checks begin only on start.

## Test plan
- Slave model returns 0 / 1370770100, waitrequest=0, start pulse → done 3 edges later; id_ok=ts_ok=ok=1, timeout=0.
- Word 1 returns 1370770101 → ts_ok=0, id_ok=1, ok=0, ts_value=1370770101.
- waitrequest held 2 cycles on each read → done 7 edges after start; m_address/m_read stable during stalls.
- TIMEOUT_CYCLES=4, waitrequest stuck high → m_read drops after 4 stall cycles, timeout=1, ok=0, done pulse.
- reset asserted during RD_TS → m_read=0 and all outputs at reset values next cycle, no done. A start pulse during busy produces no second check.
- With SYSID_CHECKER_PERIODIC_EN, RECHECK_CYCLES=10 → first check starts 10 cycles after reset release and repeats 10 idle cycles after each done.
